// File: rtl/spi_slave_ctrl_gen.sv
// spi_slave_ctrl_gen: SPI slave protocol controller in the sclk domain.
// Sits between the RX/TX shift-register front end and the AXI-side FIFOs.
// It decodes the command, address, dummy and data phases for 1/2/4 lanes,
// auto-increments the address over bursts, and flags RX overflow and TX
// underrun. Unknown commands park the controller in ERROR until cs or reset.
// Optional feature macro: SPI_SLAVE_ADDR_WRAP_EN. When it is defined, the
// burst address returns to the start address after wrap_length words.
module spi_slave_ctrl_gen #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 8,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   sclk,
  input  logic                   sys_rst,
  input  logic                   cs,
  input  logic [1:0]             cfg_lanes,
  input  logic [CNT_WIDTH-1:0]   cfg_dummy,
  input  logic [DATA_WIDTH-1:0]  rx_data,
  input  logic                   rx_data_valid,
  output logic [CNT_WIDTH-1:0]   rx_counter,
  output logic                   rx_counter_upd,
  output logic [DATA_WIDTH-1:0]  tx_data,
  output logic                   tx_data_valid,
  output logic [CNT_WIDTH-1:0]   tx_counter,
  output logic                   tx_counter_upd,
  input  logic                   tx_done,
  output logic [1:0]             pad_mode,
  output logic                   ctrl_rd_wr,
  output logic [ADDR_WIDTH-1:0]  ctrl_addr,
  output logic                   ctrl_addr_valid,
  output logic [DATA_WIDTH-1:0]  ctrl_data_rx,
  output logic                   ctrl_data_rx_valid,
  input  logic                   ctrl_data_rx_ready,
  input  logic [DATA_WIDTH-1:0]  ctrl_data_tx,
  input  logic                   ctrl_data_tx_valid,
  output logic                   ctrl_data_tx_ready,
  input  logic [15:0]            wrap_length,
  output logic                   rx_overflow,
  output logic                   tx_underrun,
  output logic [BURST_WIDTH-1:0] burst_count
);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_DUMMY, S_DATA_RX, S_DATA_TX, S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  // log2 of the lane count; the reserved encoding 11 behaves as one lane
  function automatic logic [1:0] lane_shift(input logic [1:0] l);
    case (l)
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Shifter count load: bits per lane minus one
  function automatic logic [CNT_WIDTH-1:0] cnt_load(input int bits, input logic [1:0] l);
    int v;
    v = (bits >>> lane_shift(l)) - 1;
    return CNT_WIDTH'(v);
  endfunction

  // Burst counter increments and sticks at all-ones
  function automatic logic [BURST_WIDTH-1:0] sat_inc(input logic [BURST_WIDTH-1:0] v);
    return (&v) ? v : v + BURST_WIDTH'(1);
  endfunction

  state_t                  state_q, state_d;
  logic [1:0]              lanes_q, lanes_d;
  logic                    rd_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_d, addr_next, start_q, start_d;
  logic [BURST_WIDTH-1:0]  burst_d;
  logic [CNT_WIDTH-1:0]    rx_cnt_d, tx_cnt_d;
  logic                    rx_upd_d, tx_upd_d;
  logic [DATA_WIDTH-1:0]   tx_data_d, rx_word_d;
  logic                    tx_vld_d, rx_vld_d, tx_rdy_d, addr_vld_d;
  logic                    ovf_d, unf_d;
  logic [1:0]              pad_d;
  logic                    word_done, fetch;
`ifdef SPI_SLAVE_ADDR_WRAP_EN
  logic [15:0]             wrap_q, wrap_d, wrap_next;
`else
  logic                    unused_wrap;
  assign unused_wrap = ^wrap_length;
`endif

  // Next word address: linear, or folded back to the burst start when wrapping
  always_comb begin
    addr_next = ctrl_addr + ADDR_STEP;
`ifdef SPI_SLAVE_ADDR_WRAP_EN
    wrap_next = wrap_q + 16'd1;
    if ((wrap_length != 16'd0) && (wrap_next == wrap_length)) begin
      addr_next = start_q;
      wrap_next = 16'd0;
    end
`endif
  end

  // State register; cs acts as a synchronous abort just like reset
  always_ff @(posedge sclk) begin
    if (sys_rst || cs) state_q <= S_CMD;
    else               state_q <= state_d;
  end

  // Next-state decode and next values of every registered output
  always_comb begin
    state_d    = state_q;
    lanes_d    = (state_q == S_CMD) ? cfg_lanes : lanes_q;
    rd_wr_d    = ctrl_rd_wr;
    addr_d     = ctrl_addr;
    start_d    = start_q;
    burst_d    = burst_count;
    rx_cnt_d   = rx_counter;
    rx_upd_d   = 1'b0;
    tx_cnt_d   = tx_counter;
    tx_upd_d   = 1'b0;
    tx_data_d  = tx_data;
    tx_vld_d   = 1'b0;
    rx_word_d  = ctrl_data_rx;
    rx_vld_d   = 1'b0;
    tx_rdy_d   = 1'b0;
    addr_vld_d = 1'b0;
    ovf_d      = rx_overflow;
    unf_d      = tx_underrun;
    word_done  = 1'b0;
    fetch      = 1'b0;
`ifdef SPI_SLAVE_ADDR_WRAP_EN
    wrap_d     = wrap_q;
`endif
    case (state_q)
      S_CMD: begin
        if (rx_data_valid) begin
          if (rx_data[7:0] == 8'h02 || rx_data[7:0] == 8'h0B) begin
            state_d  = S_ADDR;
            rd_wr_d  = (rx_data[7:0] == 8'h0B);
            rx_upd_d = 1'b1;
            rx_cnt_d = cnt_load(ADDR_WIDTH, lanes_d);
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_ADDR: begin
        if (rx_data_valid) begin
          addr_d     = ADDR_WIDTH'(rx_data);
          start_d    = ADDR_WIDTH'(rx_data);
          addr_vld_d = 1'b1;
`ifdef SPI_SLAVE_ADDR_WRAP_EN
          wrap_d     = 16'd0;
`endif
          if (!ctrl_rd_wr) begin
            state_d  = S_DATA_RX;
            rx_upd_d = 1'b1;
            rx_cnt_d = cnt_load(DATA_WIDTH, lanes_q);
          end else if (cfg_dummy != '0) begin
            state_d  = S_DUMMY;
            rx_upd_d = 1'b1;
            rx_cnt_d = cfg_dummy - CNT_WIDTH'(1);
          end else begin
            state_d = S_DATA_TX;
            fetch   = 1'b1;
          end
        end
      end
      S_DUMMY: begin
        if (rx_data_valid) begin
          state_d = S_DATA_TX;
          fetch   = 1'b1;
        end
      end
      S_DATA_RX: begin
        if (rx_data_valid) begin
          rx_word_d = rx_data;
          rx_vld_d  = 1'b1;
          if (!ctrl_data_rx_ready) ovf_d = 1'b1;
          word_done = 1'b1;
          rx_upd_d  = 1'b1;
          rx_cnt_d  = cnt_load(DATA_WIDTH, lanes_q);
        end
      end
      S_DATA_TX: begin
        if (tx_done) begin
          word_done = 1'b1;
          fetch     = 1'b1;
        end
      end
      default: ;
    endcase

    if (word_done) begin
      burst_d    = sat_inc(burst_count);
      addr_d     = addr_next;
      addr_vld_d = 1'b1;
`ifdef SPI_SLAVE_ADDR_WRAP_EN
      wrap_d     = wrap_next;
`endif
    end

    // Pop one word from the TX FIFO; an empty FIFO sends zeros
    if (fetch) begin
      tx_rdy_d  = 1'b1;
      tx_vld_d  = 1'b1;
      tx_data_d = ctrl_data_tx_valid ? ctrl_data_tx : '0;
      if (!ctrl_data_tx_valid) unf_d = 1'b1;
      tx_upd_d  = 1'b1;
      tx_cnt_d  = cnt_load(DATA_WIDTH, lanes_q);
    end

    if (lane_shift(lanes_d) != 2'd0)
      pad_d = (state_d == S_DATA_TX) ? 2'b01 : 2'b10;
    else
      pad_d = 2'b00;
  end

  // Output and context registers; abort reloads the command-phase count
  always_ff @(posedge sclk) begin
    if (sys_rst || cs) begin
      lanes_q            <= cfg_lanes;
      start_q            <= '0;
      rx_counter         <= cnt_load(8, cfg_lanes);
      rx_counter_upd     <= 1'b1;
      tx_data            <= '0;
      tx_data_valid      <= 1'b0;
      tx_counter         <= '0;
      tx_counter_upd     <= 1'b0;
      pad_mode           <= 2'b00;
      ctrl_rd_wr         <= 1'b0;
      ctrl_addr          <= '0;
      ctrl_addr_valid    <= 1'b0;
      ctrl_data_rx       <= '0;
      ctrl_data_rx_valid <= 1'b0;
      ctrl_data_tx_ready <= 1'b0;
      rx_overflow        <= 1'b0;
      tx_underrun        <= 1'b0;
      burst_count        <= '0;
`ifdef SPI_SLAVE_ADDR_WRAP_EN
      wrap_q             <= 16'd0;
`endif
    end else begin
      lanes_q            <= lanes_d;
      start_q            <= start_d;
      rx_counter         <= rx_cnt_d;
      rx_counter_upd     <= rx_upd_d;
      tx_data            <= tx_data_d;
      tx_data_valid      <= tx_vld_d;
      tx_counter         <= tx_cnt_d;
      tx_counter_upd     <= tx_upd_d;
      pad_mode           <= pad_d;
      ctrl_rd_wr         <= rd_wr_d;
      ctrl_addr          <= addr_d;
      ctrl_addr_valid    <= addr_vld_d;
      ctrl_data_rx       <= rx_word_d;
      ctrl_data_rx_valid <= rx_vld_d;
      ctrl_data_tx_ready <= tx_rdy_d;
      rx_overflow        <= ovf_d;
      tx_underrun        <= unf_d;
      burst_count        <= burst_d;
`ifdef SPI_SLAVE_ADDR_WRAP_EN
      wrap_q             <= wrap_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl_gen.sv
// Directed testbench for spi_slave_ctrl_gen (default parameters).
module tb_spi_slave_ctrl_gen;

  logic        sclk = 1'b0;
  logic        sys_rst, cs;
  logic [1:0]  cfg_lanes;
  logic [7:0]  cfg_dummy;
  logic [31:0] rx_data;
  logic        rx_data_valid;
  logic [7:0]  rx_counter;
  logic        rx_counter_upd;
  logic [31:0] tx_data;
  logic        tx_data_valid;
  logic [7:0]  tx_counter;
  logic        tx_counter_upd;
  logic        tx_done;
  logic [1:0]  pad_mode;
  logic        ctrl_rd_wr;
  logic [31:0] ctrl_addr;
  logic        ctrl_addr_valid;
  logic [31:0] ctrl_data_rx;
  logic        ctrl_data_rx_valid;
  logic        ctrl_data_rx_ready;
  logic [31:0] ctrl_data_tx;
  logic        ctrl_data_tx_valid;
  logic        ctrl_data_tx_ready;
  logic [15:0] wrap_length;
  logic        rx_overflow, tx_underrun;
  logic [15:0] burst_count;

  int n_assert = 0;
  int n_fail   = 0;

  spi_slave_ctrl_gen dut (
    .sclk(sclk), .sys_rst(sys_rst), .cs(cs),
    .cfg_lanes(cfg_lanes), .cfg_dummy(cfg_dummy),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_counter(rx_counter), .rx_counter_upd(rx_counter_upd),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_counter(tx_counter), .tx_counter_upd(tx_counter_upd),
    .tx_done(tx_done), .pad_mode(pad_mode), .ctrl_rd_wr(ctrl_rd_wr),
    .ctrl_addr(ctrl_addr), .ctrl_addr_valid(ctrl_addr_valid),
    .ctrl_data_rx(ctrl_data_rx), .ctrl_data_rx_valid(ctrl_data_rx_valid),
    .ctrl_data_rx_ready(ctrl_data_rx_ready),
    .ctrl_data_tx(ctrl_data_tx), .ctrl_data_tx_valid(ctrl_data_tx_valid),
    .ctrl_data_tx_ready(ctrl_data_tx_ready),
    .wrap_length(wrap_length), .rx_overflow(rx_overflow),
    .tx_underrun(tx_underrun), .burst_count(burst_count)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [31:0] d);
    rx_data       = d;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic pulse_cs();
    cs = 1'b1;
    tick();
    cs = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; cs = 1'b0; cfg_lanes = 2'b00; cfg_dummy = 8'd0;
    rx_data = '0; rx_data_valid = 1'b0; tx_done = 1'b0;
    ctrl_data_rx_ready = 1'b1; ctrl_data_tx = '0; ctrl_data_tx_valid = 1'b0;
    wrap_length = 16'd0;

    // Reset state
    tick(); tick();
    chk("rst_rx_cnt", rx_counter, 64'd7);
    chk("rst_rx_upd", rx_counter_upd, 64'd1);
    chk("rst_pad", pad_mode, 64'd0);
    chk("rst_burst", burst_count, 64'd0);
    chk("rst_txv", tx_data_valid, 64'd0);
    sys_rst = 1'b0;
    tick();
    chk("rel_rx_upd", rx_counter_upd, 64'd0);

    // Single-lane write burst of three words at 0x1000
    send_rx(32'h02);
    chk("wr_cmd_cnt", rx_counter, 64'd31);
    chk("wr_cmd_upd", rx_counter_upd, 64'd1);
    chk("wr_rdwr", ctrl_rd_wr, 64'd0);
    send_rx(32'h1000);
    chk("wr_addr", ctrl_addr, 64'h1000);
    chk("wr_addr_vld", ctrl_addr_valid, 64'd1);
    send_rx(32'hA5A50001);
    chk("wr_w1_vld", ctrl_data_rx_valid, 64'd1);
    chk("wr_w1_dat", ctrl_data_rx, 64'hA5A50001);
    chk("wr_w1_addr", ctrl_addr, 64'h1004);
    tick();
    chk("wr_idle_vld", ctrl_data_rx_valid, 64'd0);
    send_rx(32'hA5A50002);
    chk("wr_w2_addr", ctrl_addr, 64'h1008);
    chk("wr_w2_burst", burst_count, 64'd2);
    send_rx(32'hA5A50003);
    chk("wr_w3_vld", ctrl_data_rx_valid, 64'd1);
    chk("wr_w3_burst", burst_count, 64'd3);
    chk("wr_ovf", rx_overflow, 64'd0);

    // Quad-lane read with 8 dummy cycles
    cfg_lanes = 2'b10; cfg_dummy = 8'd8;
    pulse_cs();
    chk("cs_burst", burst_count, 64'd0);
    chk("q_cmd_cnt", rx_counter, 64'd1);
    chk("q_cmd_upd", rx_counter_upd, 64'd1);
    tick();
    chk("q_pad_cmd", pad_mode, 64'd2);
    send_rx(32'h0B);
    chk("q_addr_cnt", rx_counter, 64'd7);
    chk("q_rdwr", ctrl_rd_wr, 64'd1);
    send_rx(32'h40);
    chk("q_dummy_cnt", rx_counter, 64'd7);
    chk("q_dummy_upd", rx_counter_upd, 64'd1);
    chk("q_pad_dummy", pad_mode, 64'd2);
    chk("q_addr", ctrl_addr, 64'h40);
    ctrl_data_tx = 32'hDEADBEEF; ctrl_data_tx_valid = 1'b1;
    send_rx(32'h0);
    chk("q_txv", tx_data_valid, 64'd1);
    chk("q_txd", tx_data, 64'hDEADBEEF);
    chk("q_tx_cnt", tx_counter, 64'd7);
    chk("q_tx_upd", tx_counter_upd, 64'd1);
    chk("q_tx_rdy", ctrl_data_tx_ready, 64'd1);
    chk("q_pad_tx", pad_mode, 64'd1);
    ctrl_data_tx = 32'h12345678;
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("q_w2_txd", tx_data, 64'h12345678);
    chk("q_w2_addr", ctrl_addr, 64'h44);
    chk("q_w2_burst", burst_count, 64'd1);
    // rx_data_valid in DATA_TX is not this state's event
    send_rx(32'h99);
    chk("q_ignore_txv", tx_data_valid, 64'd0);
    chk("q_ignore_burst", burst_count, 64'd1);
    // TX FIFO empty on the next word
    ctrl_data_tx_valid = 1'b0;
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("q_unf_txd", tx_data, 64'd0);
    chk("q_unf", tx_underrun, 64'd1);
    chk("q_unf_burst", burst_count, 64'd2);
    tick();
    chk("q_unf_sticky", tx_underrun, 64'd1);
    pulse_cs();
    chk("cs_unf_clr", tx_underrun, 64'd0);
    chk("cs_pad", pad_mode, 64'd0);

    // Read without dummy phase and empty FIFO
    cfg_lanes = 2'b00; cfg_dummy = 8'd0;
    pulse_cs();
    send_rx(32'h0B);
    send_rx(32'h80);
    chk("nd_txv", tx_data_valid, 64'd1);
    chk("nd_txd", tx_data, 64'd0);
    chk("nd_unf", tx_underrun, 64'd1);
    chk("nd_tx_cnt", tx_counter, 64'd31);

    // Write overflow and address rollover at the top of the space
    pulse_cs();
    send_rx(32'h02);
    send_rx(32'hFFFFFFFC);
    send_rx(32'h1111);
    chk("ov_w1_addr", ctrl_addr, 64'h0);
    chk("ov_w1_flag", rx_overflow, 64'd0);
    ctrl_data_rx_ready = 1'b0;
    send_rx(32'h2222);
    chk("ov_w2_vld", ctrl_data_rx_valid, 64'd1);
    chk("ov_w2_flag", rx_overflow, 64'd1);
    ctrl_data_rx_ready = 1'b1;
    send_rx(32'h3333);
    tick();
    chk("ov_hold", rx_overflow, 64'd1);
    pulse_cs();
    chk("ov_cs_clr", rx_overflow, 64'd0);

    // Unknown command parks the controller
    send_rx(32'h55);
    chk("err_cmd_upd", rx_counter_upd, 64'd0);
    send_rx(32'h11223344);
    chk("err_addr_vld", ctrl_addr_valid, 64'd0);
    send_rx(32'h55667788);
    chk("err_rx_vld", ctrl_data_rx_valid, 64'd0);
    chk("err_burst", burst_count, 64'd0);
    pulse_cs();
    send_rx(32'h02);
    chk("err_exit_upd", rx_counter_upd, 64'd1);
    chk("err_exit_cnt", rx_counter, 64'd31);

    // Burst of three words from 0x20 with wrap_length = 2
    wrap_length = 16'd2;
    pulse_cs();
    send_rx(32'h02);
    send_rx(32'h20);
    chk("wr2_start", ctrl_addr, 64'h20);
    send_rx(32'hA);
    chk("wr2_w1", ctrl_addr, 64'h24);
    send_rx(32'hB);
`ifdef SPI_SLAVE_ADDR_WRAP_EN
    chk("wr2_w2", ctrl_addr, 64'h20);
    send_rx(32'hC);
    chk("wr2_w3", ctrl_addr, 64'h24);
`else
    chk("wr2_w2", ctrl_addr, 64'h28);
    send_rx(32'hC);
    chk("wr2_w3", ctrl_addr, 64'h2C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl_gen.md
Name: spi_slave_ctrl_gen

Overview:
Parametrised next-generation SPI slave protocol controller in the sclk domain, sitting between the SPI shift-register front end (rx/tx shifters) and the AXI-side FIFOs.
Decodes command, address, dummy and data phases for 1/2/4-lane operation with programmable data width and dummy count.
Adds address auto-increment for continuous bursts, RX overflow and TX underrun flags, and a burst word counter.
Unknown commands go to an error state instead of defaulting to TX.

Parameters:
ADDR_WIDTH, 32, address phase bits; multiple of 4.
DATA_WIDTH, 32, data word bits; multiple of 8, max 64.
CNT_WIDTH, 8, width of rx/tx bit counters.
BURST_WIDTH, 16, width of burst word counter.

Ports:
sclk  in  1  SPI clock, sole clock.
sys_rst  in  1  synchronous reset, active-high.
cs  in  1  chip deselect, active-high; sampled on sclk, synchronous abort.
cfg_lanes  in  2  00=1 lane, 01=2, 10=4, 11 treated as 1; sampled only in CMD.
cfg_dummy  in  CNT_WIDTH  dummy cycles for reads; 0 = no dummy phase.
rx_data / rx_data_valid  in  DATA_WIDTH / 1  word from RX shifter (command in [7:0]; address in [ADDR_WIDTH-1:0]).
rx_counter / rx_counter_upd  out  CNT_WIDTH / 1  RX shift count load.
tx_data / tx_data_valid  out  DATA_WIDTH / 1  word to TX shifter.
tx_counter / tx_counter_upd  out  CNT_WIDTH / 1  TX shift count load.
tx_done  in  1  TX shifter finished word.
pad_mode  out  2  00 single, 01 multi-lane TX, 10 multi-lane RX.
ctrl_rd_wr  out  1  1=read transaction.
ctrl_addr / ctrl_addr_valid  out  ADDR_WIDTH / 1  current word address, 1-cycle pulse per word.
ctrl_data_rx / ctrl_data_rx_valid / ctrl_data_rx_ready  out/out/in  DATA_WIDTH/1/1.
ctrl_data_tx / ctrl_data_tx_valid / ctrl_data_tx_ready  in/in/out  DATA_WIDTH/1/1.
wrap_length  in  16  burst wrap length in words (used only with optional feature).
rx_overflow, tx_underrun  out  1  sticky flags, cleared by reset or cs.
burst_count  out  BURST_WIDTH  data words transferred in current transaction.

Behaviour:
- Reset (sys_rst=1) or cs=1 at a sclk edge: state CMD, all outputs 0 except pad_mode=00, rx_counter=8/L-1 with rx_counter_upd=1 for one cycle after release; flags and burst_count cleared. cs has priority over all events.
- L = lanes latched in CMD. Counter loads: command 8/L-1, address ADDR_WIDTH/L-1, dummy cfg_dummy-1, data DATA_WIDTH/L-1.
- All outputs registered: response 1 cycle after the triggering rx_data_valid/tx_done.
- States: CMD, ADDR, DUMMY, DATA_RX, DATA_TX, ERROR.
- CMD, rx_data_valid: 8'h02 (write) or 8'h0B (read) -> ADDR; any other -> ERROR.
- ADDR, rx_data_valid: latch address. Write -> DATA_RX. Read -> DUMMY if cfg_dummy!=0, else DATA_TX. ctrl_addr_valid pulses for the first word.
- DUMMY, rx_data_valid -> DATA_TX. ctrl_data_tx_ready pulses to fetch the first word.
- DATA_RX, rx_data_valid: ctrl_data_rx_valid=1. If ctrl_data_rx_ready=0, the word is dropped and rx_overflow is set. Address += DATA_WIDTH/8, burst_count++, stay in DATA_RX, reload counter.
- DATA_TX: tx_data_valid with ctrl_data_tx. If ctrl_data_tx_valid=0 when the word is needed, send all-zero and set tx_underrun. On tx_done: pulse ctrl_data_tx_ready, address increment, burst_count++, reload.
- pad_mode=01 in DATA_TX when L>1, 10 in other states when L>1, else 00.
- ERROR: drive nothing; leave only by cs or reset.
- Address increment wraps modulo 2^ADDR_WIDTH. burst_count saturates at all-ones.
- Simultaneous rx_data_valid and tx_done: only the one relevant to the current state is acted on.

Optional Feature:
SPI_SLAVE_ADDR_WRAP_EN: when defined, burst address wraps to the burst start address after wrap_length words (wrap_length=0 means no wrap). When undefined, wrap_length is ignored and the address increments linearly.

Test Plan:
- cfg_lanes=00, cmd 0x02, addr 0x1000, 3 words -> ctrl_addr 0x1000/0x1004/0x1008, 3 rx_valid pulses, burst_count=3.
- cfg_lanes=10, cmd 0x0B, cfg_dummy=8 -> counter loads 1,7,7,7; pad_mode 10 then 01 in DATA_TX.
- Write with ctrl_data_rx_ready=0 on word 2 -> rx_overflow=1 and held until cs.
- Read with ctrl_data_tx_valid=0 -> tx_data=0, tx_underrun=1.
- cmd 0x55 -> ERROR, no ctrl activity; cs pulse -> CMD, flags cleared.
- SPI_SLAVE_ADDR_WRAP_EN, wrap_length=2, start 0x20 -> addresses 0x20, 0x24, 0x20.
